pong_game_ctrl: RTL

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve timing, scoring, rally speed-up and win detection.
// Ball motion itself lives in a separate datapath; this block only gates it.
module pong_game_ctrl #(
  parameter int unsigned BIT_WIDTH      = 8,
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned SERVE_DELAY    = 60,
  parameter int unsigned HITS_PER_LEVEL = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_player1,
  input  logic       i_player2,
  input  logic       i_miss_left,
  input  logic       i_miss_right,
  input  logic       i_paddle_hit,
  output logic       o_ball_reset,
  output logic       o_ball_enable,
  output logic       o_serve_dir,
  output logic [1:0] o_speed_level,
  output logic [3:0] o_score1,
  output logic [3:0] o_score2,
  output logic       o_game_over,
  output logic       o_winner,
  output logic [2:0] o_state
);

  localparam int unsigned DelayW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam int unsigned LvlW   = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e            r_state, w_state_nxt;
  logic              r_p1_prev, r_p2_prev;
  logic [DelayW-1:0] r_delay, w_delay_nxt;
  logic [LvlW-1:0]   r_lvl_hits, w_lvl_hits_nxt;
  logic [1:0]        r_speed, w_speed_nxt;
  logic [3:0]        r_score1, w_score1_nxt;
  logic [3:0]        r_score2, w_score2_nxt;
  logic              r_serve_dir, w_serve_dir_nxt;

  logic w_p1_edge, w_p2_edge, w_any_edge, w_serve_done, w_win;
  logic w_unused_bit_width;

  // BIT_WIDTH sizes the external ball datapath; nothing here depends on it.
  assign w_unused_bit_width = |BIT_WIDTH;

  assign w_p1_edge    = i_player1 & ~r_p1_prev;
  assign w_p2_edge    = i_player2 & ~r_p2_prev;
  assign w_any_edge   = w_p1_edge | w_p2_edge;
  assign w_serve_done = i_tick && (r_delay == DelayW'(SERVE_DELAY - 1));
  assign w_win        = (r_score1 == 4'(WIN_SCORE)) || (r_score2 == 4'(WIN_SCORE));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_any_edge) w_state_nxt = StServe;
      StServe: if (w_serve_done) w_state_nxt = StPlay;
      StPlay:  if (i_miss_left || i_miss_right) w_state_nxt = StPoint;
      StPoint: w_state_nxt = w_win ? StOver : StServe;
      StOver:  if (w_any_edge) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    o_state       = r_state;
    o_ball_enable = (r_state == StPlay);
    o_ball_reset  = (r_state != StPlay);
    o_game_over   = (r_state == StOver);
    o_winner      = (r_state == StOver) && (r_score2 == 4'(WIN_SCORE));
    o_serve_dir   = r_serve_dir;
    o_speed_level = r_speed;
    o_score1      = r_score1;
    o_score2      = r_score2;
  end

  always_comb begin
    w_delay_nxt     = r_delay;
    w_lvl_hits_nxt  = r_lvl_hits;
    w_speed_nxt     = r_speed;
    w_score1_nxt    = r_score1;
    w_score2_nxt    = r_score2;
    w_serve_dir_nxt = r_serve_dir;
    case (r_state)
      StIdle: begin
        if (w_any_edge) begin
          w_serve_dir_nxt = w_p1_edge;
          w_delay_nxt     = '0;
          w_lvl_hits_nxt  = '0;
          w_speed_nxt     = '0;
        end
      end
      StServe: begin
        if (i_tick) w_delay_nxt = w_serve_done ? '0 : r_delay + 1'b1;
      end
      StPlay: begin
        if (i_miss_left && !i_miss_right) begin
          if (r_score2 != 4'(WIN_SCORE)) w_score2_nxt = r_score2 + 4'd1;
          w_serve_dir_nxt = 1'b0;
        end else if (i_miss_right && !i_miss_left) begin
          if (r_score1 != 4'(WIN_SCORE)) w_score1_nxt = r_score1 + 4'd1;
          w_serve_dir_nxt = 1'b1;
        end else if (!i_miss_left && i_paddle_hit && r_speed != 2'd3) begin
          // Rally count is speed*HITS_PER_LEVEL + lvl_hits; it stops at level 3.
          if (r_lvl_hits == LvlW'(HITS_PER_LEVEL - 1)) begin
            w_lvl_hits_nxt = '0;
            w_speed_nxt    = r_speed + 2'd1;
          end else begin
            w_lvl_hits_nxt = r_lvl_hits + 1'b1;
          end
        end
      end
      StPoint: begin
        if (!w_win) begin
          w_delay_nxt    = '0;
          w_lvl_hits_nxt = '0;
          w_speed_nxt    = '0;
        end
      end
      StOver: begin
        if (w_any_edge) begin
          w_score1_nxt = '0;
          w_score2_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // History resets as "held" so a button down across reset is not an edge.
      r_p1_prev   <= 1'b1;
      r_p2_prev   <= 1'b1;
      r_delay     <= '0;
      r_lvl_hits  <= '0;
      r_speed     <= '0;
      r_score1    <= '0;
      r_score2    <= '0;
      r_serve_dir <= 1'b0;
    end else begin
      r_p1_prev   <= i_player1;
      r_p2_prev   <= i_player2;
      r_delay     <= w_delay_nxt;
      r_lvl_hits  <= w_lvl_hits_nxt;
      r_speed     <= w_speed_nxt;
      r_score1    <= w_score1_nxt;
      r_score2    <= w_score2_nxt;
      r_serve_dir <= w_serve_dir_nxt;
    end
  end

endmodule
